// File: rtl/bus_pkg.sv
// Shared system-bus definitions: transfer-type encodings, the
// master-ID width rule and the default idle address.
package bus_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Wide enough for any address width in use; users take the low bits.
    localparam logic [63:0] BUS_IDLE_ADDR = 64'h0;

    // Master-ID width: ceil(log2(n)), never narrower than one bit.
    function automatic int mw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to index encoder with validity flags.
// Ports: i_vec (N bits) -> o_idx (MW bits), o_valid (exactly one bit
// set), o_multi (more than one bit set).
module onehot_enc #(
    parameter int N  = 2,
    parameter int MW = 1
) (
    input  logic [N-1:0]  i_vec,
    output logic [MW-1:0] o_idx,
    output logic          o_valid,
    output logic          o_multi
);

    logic [MW-1:0] w_idx;
    logic          w_any;
    logic          w_multi;

    // OR-reduce the indices of set bits; only meaningful when one-hot.
    always_comb begin
        w_idx   = '0;
        w_any   = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                w_multi = w_multi | w_any;
                w_any   = 1'b1;
                w_idx   = w_idx | MW'(i);
            end
        end
    end

    assign o_idx   = w_idx;
    assign o_valid = w_any & ~w_multi;
    assign o_multi = w_multi;

endmodule

// File: rtl/addr_mux_n.sv
// Registered N-master address-phase mux with data-phase owner tracking
// and a sticky illegal-grant flag.
// Ports: CLK, RST (async low), HADDR_IN/HTRANS_IN (packed per master),
// SEL (one-hot grant), HREADY, ERR_CLR -> HADDR, HTRANS, HMASTER,
// HMASTER_D, D_VALID, SEL_ERR (all flop outputs).
module addr_mux_n
    import bus_pkg::*;
#(
    parameter int                N_MASTERS = 2,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = BUS_IDLE_ADDR[ADDR_W-1:0]
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_MASTERS*ADDR_W-1:0]   HADDR_IN,
    input  logic [N_MASTERS*2-1:0]        HTRANS_IN,
    input  logic [N_MASTERS-1:0]          SEL,
    input  logic                          HREADY,
    input  logic                          ERR_CLR,
    output logic [ADDR_W-1:0]             HADDR,
    output logic [1:0]                    HTRANS,
    output logic [mw_of(N_MASTERS)-1:0]   HMASTER,
    output logic [mw_of(N_MASTERS)-1:0]   HMASTER_D,
    output logic                          D_VALID,
    output logic                          SEL_ERR
);

    localparam int MW = mw_of(N_MASTERS);

    logic [MW-1:0]     w_idx;
    logic              w_valid;
    logic              w_multi;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_trans;

    logic [ADDR_W-1:0] r_haddr;
    logic [1:0]        r_htrans;
    logic [MW-1:0]     r_hmaster;
    logic [MW-1:0]     r_hmaster_d;
    logic              r_d_valid;
    logic              r_sel_err;

    onehot_enc #(
        .N  (N_MASTERS),
        .MW (MW)
    ) u_enc (
        .i_vec   (SEL),
        .o_idx   (w_idx),
        .o_valid (w_valid),
        .o_multi (w_multi)
    );

    // AND-OR mux gated directly by SEL; the result is only used when
    // SEL is one-hot, so no priority logic sits on the path.
    always_comb begin
        w_addr  = '0;
        w_trans = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_addr  = w_addr  | (HADDR_IN[i*ADDR_W +: ADDR_W] & {ADDR_W{SEL[i]}});
            w_trans = w_trans | (HTRANS_IN[i*2 +: 2] & {2{SEL[i]}});
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_haddr     <= IDLE_ADDR;
            r_htrans    <= HTRANS_IDLE;
            r_hmaster   <= '0;
            r_hmaster_d <= '0;
            r_d_valid   <= 1'b0;
        end else if (HREADY) begin
            // Data phase takes the address phase being retired now.
            r_hmaster_d <= r_hmaster;
            r_d_valid   <= r_htrans[1];
            if (w_valid) begin
                r_haddr   <= w_addr;
                r_htrans  <= w_trans;
                r_hmaster <= w_idx;
            end else begin
                // No or illegal grant: idle, park on the last owner.
                r_haddr  <= IDLE_ADDR;
                r_htrans <= HTRANS_IDLE;
            end
        end
    end

    // Sticky error flag; a fresh illegal grant beats a clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sel_err <= 1'b0;
        end else if (w_multi) begin
            r_sel_err <= 1'b1;
        end else if (ERR_CLR) begin
            r_sel_err <= 1'b0;
        end
    end

    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HMASTER   = r_hmaster;
    assign HMASTER_D = r_hmaster_d;
    assign D_VALID   = r_d_valid;
    assign SEL_ERR   = r_sel_err;

endmodule

// File: tb/tb_addr_mux_n.sv
// Bench for addr_mux_n: directed N=2 scenarios plus a randomized N=4
// run compared against a behavioural model of the bus rules.
module tb_addr_mux_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    logic [31:0]  haddr_in2;
    logic [3:0]   htrans_in2;
    logic [1:0]   sel2;
    logic         rdy2, clr2;
    logic [15:0]  haddr2;
    logic [1:0]   htrans2;
    logic         hm2, hmd2, dv2, err2;

    logic [127:0] haddr_in4;
    logic [7:0]   htrans_in4;
    logic [3:0]   sel4;
    logic         rdy4, clr4;
    logic [31:0]  haddr4;
    logic [1:0]   htrans4;
    logic [1:0]   hm4, hmd4;
    logic         dv4, err4;

    addr_mux_n #(.N_MASTERS(2), .ADDR_W(16)) u_dut2 (
        .CLK(clk), .RST(rst_n),
        .HADDR_IN(haddr_in2), .HTRANS_IN(htrans_in2),
        .SEL(sel2), .HREADY(rdy2), .ERR_CLR(clr2),
        .HADDR(haddr2), .HTRANS(htrans2), .HMASTER(hm2),
        .HMASTER_D(hmd2), .D_VALID(dv2), .SEL_ERR(err2)
    );

    addr_mux_n #(.N_MASTERS(4), .ADDR_W(32)) u_dut4 (
        .CLK(clk), .RST(rst_n),
        .HADDR_IN(haddr_in4), .HTRANS_IN(htrans_in4),
        .SEL(sel4), .HREADY(rdy4), .ERR_CLR(clr4),
        .HADDR(haddr4), .HTRANS(htrans4), .HMASTER(hm4),
        .HMASTER_D(hmd4), .D_VALID(dv4), .SEL_ERR(err4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        haddr_in2 = {16'h1234, 16'hABCD};
        htrans_in2 = 4'b0010;
        sel2 = 2'b01; rdy2 = 1'b1; clr2 = 1'b0;
        haddr_in4 = '0; htrans_in4 = '0;
        sel4 = '0; rdy4 = 1'b1; clr4 = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        step();
        total++;
        if (haddr2 !== 16'hABCD || dv2 !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset haddr=%h dv=%b exp=abcd/1", haddr2, dv2);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({haddr2, htrans2, hm2, hmd2, dv2, err2} !== 22'h0) begin
            bad++;
            $display("FAIL async_reset2 got=%h exp=0",
                     {haddr2, htrans2, hm2, hmd2, dv2, err2});
        end
        total++;
        if ({haddr4, htrans4, hm4, hmd4, dv4, err4} !== 40'h0) begin
            bad++;
            $display("FAIL async_reset4 got=%h exp=0",
                     {haddr4, htrans4, hm4, hmd4, dv4, err4});
        end
        sel2 = 2'b00;
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (haddr2 !== 16'h0000 || htrans2 !== 2'b00) begin
            bad++;
            $display("FAIL post_release haddr=%h htrans=%b exp=0000/00",
                     haddr2, htrans2);
        end
    endtask

    task automatic test_single();
        sel2 = 2'b01;
        haddr_in2 = {16'h1234, 16'hABCD};
        htrans_in2 = 4'b0010;
        step();
        total++;
        if (haddr2 !== 16'hABCD || htrans2 !== 2'b10 || hm2 !== 1'b0) begin
            bad++;
            $display("FAIL single_addr got=%h/%b/%b exp=abcd/10/0",
                     haddr2, htrans2, hm2);
        end
        step();
        total++;
        if (hmd2 !== 1'b0 || dv2 !== 1'b1) begin
            bad++;
            $display("FAIL single_data got=%b/%b exp=0/1", hmd2, dv2);
        end
    endtask

    task automatic test_switch_stall();
        sel2 = 2'b10;
        rdy2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (haddr2 !== 16'hABCD || hm2 !== 1'b0 || dv2 !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold%0d got=%h/%b/%b exp=abcd/0/1",
                         i, haddr2, hm2, dv2);
            end
        end
        rdy2 = 1'b1;
        step();
        total++;
        if (haddr2 !== 16'h1234 || hm2 !== 1'b1 || htrans2 !== 2'b00) begin
            bad++;
            $display("FAIL switch got=%h/%b/%b exp=1234/1/00",
                     haddr2, hm2, htrans2);
        end
        total++;
        if (hmd2 !== 1'b0 || dv2 !== 1'b1) begin
            bad++;
            $display("FAIL switch_data got=%b/%b exp=0/1", hmd2, dv2);
        end
    endtask

    task automatic test_parking();
        sel2 = 2'b00;
        step();
        total++;
        if (haddr2 !== 16'h0 || htrans2 !== 2'b00 || hm2 !== 1'b1) begin
            bad++;
            $display("FAIL park got=%h/%b/%b exp=0000/00/1",
                     haddr2, htrans2, hm2);
        end
        step();
        total++;
        if (hm2 !== 1'b1 || hmd2 !== 1'b1 || dv2 !== 1'b0) begin
            bad++;
            $display("FAIL park_data got=%b/%b/%b exp=1/1/0", hm2, hmd2, dv2);
        end
    endtask

    task automatic test_illegal();
        sel2 = 2'b10;
        step();
        sel2 = 2'b11;
        step();
        total++;
        if (haddr2 !== 16'h0 || htrans2 !== 2'b00 || hm2 !== 1'b1 ||
            err2 !== 1'b1) begin
            bad++;
            $display("FAIL illegal got=%h/%b/%b/%b exp=0000/00/1/1",
                     haddr2, htrans2, hm2, err2);
        end
        sel2 = 2'b01;
        step();
        total++;
        if (err2 !== 1'b1 || haddr2 !== 16'hABCD) begin
            bad++;
            $display("FAIL err_sticky got=%b/%h exp=1/abcd", err2, haddr2);
        end
        sel2 = 2'b11; clr2 = 1'b1;
        step();
        total++;
        if (err2 !== 1'b1) begin
            bad++;
            $display("FAIL set_wins got=%b exp=1", err2);
        end
        sel2 = 2'b01;
        step();
        total++;
        if (err2 !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%b exp=0", err2);
        end
        clr2 = 1'b0; sel2 = 2'b11; rdy2 = 1'b0;
        step();
        total++;
        if (err2 !== 1'b1 || haddr2 !== 16'hABCD) begin
            bad++;
            $display("FAIL err_stalled got=%b/%h exp=1/abcd", err2, haddr2);
        end
        rdy2 = 1'b1; sel2 = 2'b01; clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        total++;
        if (err2 !== 1'b0) begin
            bad++;
            $display("FAIL err_clear2 got=%b exp=0", err2);
        end
    endtask

    task automatic test_scale();
        logic [31:0] a [4];
        logic [1:0]  t [4];
        logic [31:0] m_addr = '0;
        logic [1:0]  m_trans = '0;
        int          m_mst = 0;
        int          m_mst_d = 0;
        bit          m_dv = 1'b0;
        int          errs = 0;
        int          k;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = $urandom;
                t[i] = 2'($urandom_range(0, 3));
            end
            haddr_in4 = {a[3], a[2], a[1], a[0]};
            htrans_in4 = {t[3], t[2], t[1], t[0]};
            if ($urandom_range(0, 9) == 0) sel4 = 4'b0000;
            else sel4 = 4'b0001 << $urandom_range(0, 3);
            rdy4 = ($urandom_range(0, 3) != 0);
            if (rdy4) begin
                m_mst_d = m_mst;
                m_dv = (m_trans == 2'b10 || m_trans == 2'b11);
                if (sel4 != 4'b0000) begin
                    k = 0;
                    for (int j = 0; j < 4; j++) if (sel4[j]) k = j;
                    m_addr = a[k];
                    m_trans = t[k];
                    m_mst = k;
                end else begin
                    m_addr = '0;
                    m_trans = 2'b00;
                end
            end
            step();
            total++;
            if (haddr4 !== m_addr || htrans4 !== m_trans ||
                hm4 !== 2'(m_mst) || hmd4 !== 2'(m_mst_d) ||
                dv4 !== m_dv) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL scale%0d got=%h/%b/%0d/%0d/%b exp=%h/%b/%0d/%0d/%b",
                             n, haddr4, htrans4, hm4, hmd4, dv4,
                             m_addr, m_trans, m_mst, m_mst_d, m_dv);
            end
        end
        total++;
        if (err4 !== 1'b0) begin
            bad++;
            $display("FAIL scale_err got=%b exp=0", err4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_switch_stall();
        test_parking();
        test_illegal();
        test_scale();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addr_mux_n.md
# addr_mux_n

Parametrised, registered address-phase multiplexer for the system bus. It is the next generation of the two-master address mux and supports N masters of configurable address width. It forwards the granted master's address and transfer type only when the bus accepts an address phase (HREADY high). It also tracks the master owning the following data phase and flags illegal grant vectors. It sits between the arbiter (which supplies SEL) and the slave decoder/slave address inputs.

## Interface
Parameters:
- N_MASTERS, 2, number of masters (2..16)
- ADDR_W, 16, address width in bits
- IDLE_ADDR, 0, address driven when no valid grant exists (ADDR_W bits)
- MW, $clog2(N_MASTERS) with a minimum of 1, master-ID width (derived, not overridable)

Ports:
- CLK  in  1  bus clock; all flops rise-edge
- RST  in  1  asynchronous, active-low reset
- HADDR_IN  in  N_MASTERS*ADDR_W  master addresses, packed; master i at [i*ADDR_W +: ADDR_W]
- HTRANS_IN  in  N_MASTERS*2  master transfer types, packed; master i at [i*2 +: 2]; 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- SEL  in  N_MASTERS  one-hot grant from arbiter; all-zero means no master
- HREADY  in  1  bus ready; 1 means the current address phase is accepted this cycle
- ERR_CLR  in  1  synchronous clear of SEL_ERR
- HADDR  out  ADDR_W  registered bus address
- HTRANS  out  2  registered bus transfer type
- HMASTER  out  MW  ID of the master owning the current address phase
- HMASTER_D  out  MW  ID of the master owning the current data phase
- D_VALID  out  1  current data phase carries a real transfer (NONSEQ or SEQ)
- SEL_ERR  out  1  sticky flag; SEL was seen with more than one bit set

## Operation
- Address stage updates only on a rising CLK with HREADY=1. When HREADY=0, all outputs hold, including HMASTER_D and D_VALID.
- SEL exactly one-hot, bit k set: HADDR ← HADDR_IN[k], HTRANS ← HTRANS_IN[k], HMASTER ← k.
- SEL all-zero: HADDR ← IDLE_ADDR, HTRANS ← 00, HMASTER holds its previous value (bus parking).
- SEL with more than one bit set: same outputs as the all-zero case, and SEL_ERR ← 1. The lowest set bit is never used.
- Data stage, on the same HREADY=1 edge: HMASTER_D ← current HMASTER and D_VALID ← current HTRANS[1]. Both take pre-update values, so the data phase lags the address phase by exactly one accepted transfer.
- SEL_ERR: set by a multi-bit SEL on any edge, regardless of HREADY. Cleared by ERR_CLR=1 at an edge. If a set and a clear occur on the same edge, set wins.
- Reset (RST=0, asynchronous): HADDR=IDLE_ADDR, HTRANS=00, HMASTER=0, HMASTER_D=0, D_VALID=0, SEL_ERR=0. Release is synchronised by the system; the first update happens on the first edge with RST=1.
- Reset mid-transfer aborts the pipeline with no recovery state; D_VALID reads 0 immediately.

## Timing
- Latency: an accepted SEL/HADDR_IN at edge n appears on HADDR/HTRANS/HMASTER after edge n. The data-phase fields for that transfer appear after the next accepted edge.
- Every output is a flop output; there is no combinational path from any input to any output.
- Critical path: N-way AND-OR mux plus the one-hot check, targeting a single cycle at bus clock.
- Back-to-back master changes on consecutive accepted edges are legal with no bubble.

## Structure
- Shared package bus_pkg holds:
  - HTRANS encodings (HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ)
  - the MW derivation function
  - a default IDLE_ADDR constant, shared with the decoder and data mux
- One sub-module, onehot_enc: N-bit vector to MW-bit index plus valid and multi flags, combinational. It is reused later by the data mux and response mux.
- The top holds the address register, data-phase register and error flop.

## Test plan
- Reset: drive RST=0 mid-run with SEL=01 → all outputs go to their reset values within the same cycle; after release with SEL=00 and HREADY=1, HADDR=0000 and HTRANS=00.
- Single master: N=2, SEL=01, HADDR_IN=ABCD/1234, HTRANS_IN=10/00, HREADY=1 → next edge HADDR=ABCD, HTRANS=10, HMASTER=0; following edge HMASTER_D=0, D_VALID=1.
- Switch with stall: SEL=01 then 10 with HREADY=0 for 3 cycles → HADDR holds ABCD for all 3 cycles, then goes to 1234 and HMASTER=1 on the first HREADY=1 edge.
- No grant / parking: SEL=00 after master 1 → HADDR=IDLE_ADDR, HTRANS=00, HMASTER stays 1, D_VALID=0 one accepted edge later.
- Illegal grant: SEL=11 → HADDR=IDLE_ADDR and SEL_ERR=1. SEL_ERR stays set through SEL=01. With ERR_CLR=1 and SEL=11 on the same edge, SEL_ERR stays 1. ERR_CLR=1 with SEL=01 clears it.
- Scale: N=4, ADDR_W=32 with random addresses and one-hot SEL over 1000 cycles and random HREADY → a scoreboard matches HADDR, HMASTER, HMASTER_D and D_VALID against a reference model.
